// File: rtl/tps_pkg.sv
// tps_pkg: shared types, saturation constant and popcount helper for toggle_power_sampler
package tps_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, ACCUM} state_t;
  localparam int POP_W = 1024;
  localparam int DEF_SAMPLE_W = 16;
  localparam logic [DEF_SAMPLE_W-1:0] SAT_MAX = '1;
  // callers zero-extend their vector to POP_W and pass its real width
  function automatic logic [10:0] popcount(input logic [POP_W-1:0] v, input int w);
    logic [10:0] c;
    c = '0;
    for (int i = 0; i < POP_W; i++)
      if (i < w) c = c + 11'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/toggle_power_sampler_fifo.sv
// tps_sample_fifo: synchronous sample FIFO with valid/ready head that accepts a push on pop when full
module tps_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign valid = !empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/toggle_power_sampler.sv
// toggle_power_sampler: windowed Hamming-distance power trace sampler with sample FIFO
// Build option: define TPS_HW_LEAK_EN to add the Hamming-weight term to each contribution.
module toggle_power_sampler
  import tps_pkg::*;
#(
  parameter int NETS = 64,
  parameter int WINDOW = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                abort,
  input  logic [CNT_W-1:0]    n_samples,
  input  logic                net_valid,
  input  logic [NETS-1:0]     net_vec,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic                busy,
  output logic                overflow
);
  localparam int WCW = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam int XW = SAMPLE_W + 13;
  localparam logic [SAMPLE_W-1:0] SAT = '1;
  state_t state, state_d;
  logic [NETS-1:0] prev;
  logic [SAMPLE_W-1:0] acc, sum;
  logic [WCW-1:0] win_cnt;
  logic [CNT_W-1:0] smp_cnt, target;
  logic [10:0] hd;
  logic [11:0] contrib;
  logic [XW-1:0] sum_x;
  logic start, step, win_last, push, done, drop, full, empty;
`ifdef TPS_HW_LEAK_EN
  logic [10:0] hw;
`endif
  always_comb begin
    hd = popcount(POP_W'(net_vec ^ prev), NETS);
`ifdef TPS_HW_LEAK_EN
    hw = popcount(POP_W'(net_vec), NETS);
    contrib = 12'(hd) + 12'(hw);
`else
    contrib = 12'(hd);
`endif
    sum_x = XW'(acc) + XW'(contrib);
    sum = sum_x > XW'(SAT) ? SAT : sum_x[SAMPLE_W-1:0];
  end
  assign start = state == IDLE && arm;
  assign step = state == ACCUM && net_valid && !abort;
  assign win_last = win_cnt == WCW'(WINDOW - 1);
  assign push = step && win_last;
  assign done = push && target != '0 && smp_cnt + CNT_W'(1) == target;
  // a dropped sample still counts toward n_samples; only the flag records the loss
  assign drop = push && full && !(smp_valid && smp_ready);
  assign busy = state == PRIME || state == ACCUM;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  state_d = arm ? PRIME : IDLE;
      PRIME: state_d = abort ? IDLE : net_valid ? ACCUM : PRIME;
      ACCUM: state_d = abort || done ? IDLE : ACCUM;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      prev <= '0;
      acc <= '0;
      win_cnt <= '0;
      smp_cnt <= '0;
      target <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      if (start) begin
        target <= n_samples;
        acc <= '0;
        win_cnt <= '0;
        smp_cnt <= '0;
        overflow <= 1'b0;
      end else if (drop) overflow <= 1'b1;
      if (state == PRIME && net_valid && !abort) prev <= net_vec;
      if (step) begin
        prev <= net_vec;
        acc <= win_last ? '0 : sum;
        win_cnt <= win_last ? '0 : win_cnt + WCW'(1);
        if (win_last) smp_cnt <= smp_cnt + CNT_W'(1);
      end
    end
  end
  tps_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(sum),
    .pop(smp_ready),
    .valid(smp_valid),
    .dout(smp_data),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/toggle_power_sampler.md
Name: toggle_power_sampler

Overview:
- Observation end of the gate-level leakage flow: consumes net-value snapshots from a simulated cell netlist.
- Computes per-cycle Hamming-distance (toggle count) power estimates and sums them over a fixed window.
- Emits one power-trace sample per window through a valid/ready stream, buffered in a small FIFO, for off-line side-channel analysis.

Parameters:
- NETS, 64, width of the observed net vector.
- WINDOW, 4, valid snapshots summed per sample (>=1).
- FIFO_DEPTH, 8, sample FIFO entries (power of 2, >=2).
- SAMPLE_W, 16, sample width; the accumulator saturates at this width.
- CNT_W, 16, width of the sample-count input.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- arm  in  1  starts a capture; ignored while busy.
- abort  in  1  ends the capture and discards the partial window.
- n_samples  in  CNT_W  samples to capture; sampled on arm; 0 = free-running until abort.
- net_valid  in  1  net_vec holds a new snapshot this cycle.
- net_vec  in  NETS  snapshot of the observed nets.
- smp_valid  out  1  FIFO head is valid.
- smp_ready  in  1  consumer accepts the head.
- smp_data  out  SAMPLE_W  FIFO head sample.
- busy  out  1  high in PRIME or ACCUM.
- overflow  out  1  sticky: at least one sample dropped.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; FIFO is emptied.
  - All outputs 0: smp_valid, smp_data, busy, overflow.
  - Accumulator, window counter, sample counter and snapshot register are all 0.
  - Reset mid-capture discards everything; no sample is produced.
- IDLE:
  - On arm=1: latch n_samples, clear overflow, accumulator and counters, then go to PRIME.
- PRIME:
  - First net_valid stores net_vec as prev; no sample contribution; go to ACCUM.
- ACCUM, on each net_valid:
  - hd = popcount(net_vec ^ prev); prev <= net_vec.
  - sum = acc + hd, saturated to 2^SAMPLE_W-1.
  - If win_cnt == WINDOW-1: push sum to the FIFO, set acc=0 and win_cnt=0, and increment the sample count. Otherwise acc <= sum and win_cnt++.
  - When the pushed sample is the n_samples-th one (n_samples != 0), go to IDLE in the same edge.
- Cycles with net_valid=0 change nothing.
- abort=1 in PRIME or ACCUM:
  - Go to IDLE; the partial window is discarded.
  - FIFO contents are kept and remain drainable.
  - abort has priority over a push in the same cycle.
- abort in IDLE has no effect. arm while busy is ignored.
- Latency: a sample pushed at edge t appears on smp_valid/smp_data after edge t (same-cycle visibility) if the FIFO was empty.
- FIFO:
  - Pop on smp_valid && smp_ready.
  - Push while full with no simultaneous pop: the sample is dropped, overflow <= 1, and the sample still counts toward n_samples.
  - Push and pop in the same cycle while full: the push is accepted.
  - Order is FIFO; data is held stable while smp_valid && !smp_ready.
- busy = (state==PRIME || state==ACCUM). It drops in the cycle after the final push or abort.

Optional Feature:
- Macro: TPS_HW_LEAK_EN.
- When defined: each ACCUM contribution becomes hd + popcount(net_vec), combining the Hamming-distance and Hamming-weight models. Saturation is unchanged.
- When undefined: the contribution is hd only.

Decomposition:
- Package tps_pkg holds:
  - state enum {IDLE, PRIME, ACCUM};
  - popcount function parameterised by width;
  - constant for the saturation value.
- One sub-module, tps_sample_fifo: synchronous FIFO with valid/ready output, full/empty flags and accept-push-on-pop-when-full.

Test Plan:
All scenarios run with NETS=8, WINDOW=4, FIFO_DEPTH=4, SAMPLE_W=16.
1. arm, n_samples=1, net_vec 0x00,0xFF,0x00,0xFF,0x00 (all valid) -> one sample 32; smp_valid right after the 5th snapshot; busy then 0.
2. arm, n_samples=2, net_vec constant 0xA5 for 9 snapshots -> samples 0,0. Then rerun with net_valid=0 on every other cycle -> identical samples.
3. smp_ready=0, n_samples=6, alternating 0x00/0x01 -> FIFO holds four samples of 4 each; overflow=1; raising smp_ready drains exactly 4 in order, then smp_valid=0.
4. abort after 2 of 4 ACCUM snapshots -> no push, busy=0 next cycle; a new arm clears overflow.
5. rst_n=0 for one cycle with 2 samples queued and mid-window -> smp_valid=0, busy=0, overflow=0 after the edge.
6. With TPS_HW_LEAK_EN: net_vec 0x00, then 0x0F four times -> sample 4+16=20. Without the macro the same stimulus gives 4.
